// File: rtl/fas_analysis.sv
// fas_analysis: finds the peak-magnitude bin of a 16-bin FFT frame, one bin per clock, with a one-deep shadow buffer.
// Build option: define ANALYSIS_L1_MAG_EN to use |re|+|im| instead of re*re+im*im as the magnitude.
module fas_analysis #(
  parameter int IGNORE_DC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq,
  output logic [32:0] peak,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [3:0]    cnt_r;
  logic [31:0]   work_r [16];
  logic [31:0]   shad_r [16];
  logic          shad_full_r;
  logic [32:0]   max_r;
  logic [3:0]    idx_r;

  logic [31:0]        in_s [16];
  logic [31:0]        bin_s;
  logic signed [15:0] re_s;
  logic signed [15:0] im_s;
  logic [32:0]        mag_s;
  logic               skip_s;
  logic               upd_s;
  logic               last_s;
  logic [32:0]        best_mag_s;
  logic [3:0]         best_idx_s;
  logic               start_s;
  logic               load_new_s;
  logic               load_from_shad_s;
  logic               load_shad_s;
  logic               clr_shad_s;
  logic               set_ovf_s;

  assign in_s[0]  = fft_d0;
  assign in_s[1]  = fft_d1;
  assign in_s[2]  = fft_d2;
  assign in_s[3]  = fft_d3;
  assign in_s[4]  = fft_d4;
  assign in_s[5]  = fft_d5;
  assign in_s[6]  = fft_d6;
  assign in_s[7]  = fft_d7;
  assign in_s[8]  = fft_d8;
  assign in_s[9]  = fft_d9;
  assign in_s[10] = fft_d10;
  assign in_s[11] = fft_d11;
  assign in_s[12] = fft_d12;
  assign in_s[13] = fft_d13;
  assign in_s[14] = fft_d14;
  assign in_s[15] = fft_d15;

  assign bin_s = work_r[cnt_r];
  assign re_s  = bin_s[31:16];
  assign im_s  = bin_s[15:0];

`ifdef ANALYSIS_L1_MAG_EN
  function automatic logic [16:0] abs16(input logic [15:0] v);
    if (v[15]) begin
      abs16 = {1'b0, ~v} + 17'd1;
    end else begin
      abs16 = {1'b0, v};
    end
  endfunction

  logic [16:0] l1_s;
  assign l1_s  = abs16(re_s) + abs16(im_s);
  assign mag_s = {16'd0, l1_s};
`else
  logic signed [31:0] re_sq_s;
  logic signed [31:0] im_sq_s;
  assign re_sq_s = re_s * re_s;
  assign im_sq_s = im_s * im_s;
  // Both squares are non-negative, so zero-extension is exact.
  assign mag_s   = {1'b0, re_sq_s} + {1'b0, im_sq_s};
`endif

  assign skip_s     = (IGNORE_DC != 0) && (cnt_r == 4'd0);
  assign upd_s      = !skip_s && (mag_s > max_r);
  assign best_mag_s = upd_s ? mag_s : max_r;
  assign best_idx_s = upd_s ? cnt_r : idx_r;
  assign last_s     = (state_r == SCAN) && (cnt_r == 4'd15);

  // Next-state and buffer-control decode.
  always_comb begin
    state_s          = state_r;
    start_s          = 1'b0;
    load_new_s       = 1'b0;
    load_from_shad_s = 1'b0;
    load_shad_s      = 1'b0;
    clr_shad_s       = 1'b0;
    set_ovf_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (fft_valid) begin
          state_s    = SCAN;
          start_s    = 1'b1;
          load_new_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (cnt_r == 4'd15) begin
          // Final edge: chain straight into the next scan when a frame is waiting.
          if (shad_full_r) begin
            start_s          = 1'b1;
            load_from_shad_s = 1'b1;
            if (fft_valid) begin
              load_shad_s = 1'b1;
            end else begin
              clr_shad_s = 1'b1;
            end
          end else if (fft_valid) begin
            start_s    = 1'b1;
            load_new_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          if (fft_valid && !shad_full_r) begin
            load_shad_s = 1'b1;
          end else if (fft_valid) begin
            set_ovf_s = 1'b1;
          end else begin
            load_shad_s = 1'b0;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Bin counter and running maximum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 4'd0;
      max_r <= 33'd0;
      idx_r <= 4'd0;
    end else if (start_s) begin
      cnt_r <= 4'd0;
      max_r <= 33'd0;
      idx_r <= 4'd0;
    end else if (state_r == SCAN) begin
      cnt_r <= cnt_r + 4'd1;
      max_r <= best_mag_s;
      idx_r <= best_idx_s;
    end
  end

  // Working and shadow frame buffers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shad_full_r <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        work_r[i] <= 32'd0;
        shad_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (load_from_shad_s) begin
          work_r[i] <= shad_r[i];
        end else if (load_new_s) begin
          work_r[i] <= in_s[i];
        end
        if (load_shad_s) begin
          shad_r[i] <= in_s[i];
        end
      end
      if (load_shad_s) begin
        shad_full_r <= 1'b1;
      end else if (clr_shad_s) begin
        shad_full_r <= 1'b0;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done     <= 1'b0;
      freq     <= 4'd0;
      peak     <= 33'd0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done     <= last_s;
      busy     <= (state_s == SCAN);
      overflow <= overflow | set_ovf_s;
      if (last_s) begin
        freq <= best_idx_s;
        peak <= best_mag_s;
      end
    end
  end

endmodule

// File: doc/fas_analysis.md
FAS_ANALYSIS -- requirements
Module: fas_analysis

Interface
REQ-001 The block SHALL have one parameter: IGNORE_DC, default 0, meaning that when set to 1, bin 0 is excluded from the peak search.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset.
REQ-003 Port clk: input, 1 bit, rising-edge clock.
REQ-004 Port rst: input, 1 bit, asynchronous active-low reset.
REQ-005 Port fft_valid: input, 1 bit, single-cycle strobe marking a valid FFT frame on fft_d0..fft_d15.
REQ-006 Ports fft_d0..fft_d15: input, 32 bits each, bin n; [31:16] signed real, [15:0] signed imaginary, 8.8 fixed point.
REQ-007 Port done: output, 1 bit, one-cycle pulse marking the end of analysis of a frame.
REQ-008 Port freq: output, 4 bits, index of the peak-magnitude bin, valid while done is high and held afterwards.
REQ-009 Port peak: output, 33 bits, unsigned magnitude of the winning bin, updated together with freq.
REQ-010 Port busy: output, 1 bit, high while a scan is in progress.
REQ-011 Port overflow: output, 1 bit, sticky flag meaning a frame was dropped.

Function
REQ-012 The working buffer SHALL capture all 16 bins on any rising edge where fft_valid=1 and no scan is running, and a scan SHALL start.
REQ-013 A scan SHALL have states IDLE and SCAN; scan edges 1..16 SHALL evaluate bins 0..15, one bin per edge.
REQ-014 On each scan edge the block SHALL compute mag = re*re + im*im, using signed 16x16 products summed into 33 bits unsigned with no saturation.
REQ-015 The running maximum SHALL update only if mag > current max (strict compare), so a tie keeps the lower index.
REQ-016 The running maximum SHALL reset to 0 with index 0 at scan start; with IGNORE_DC=1, bin 0 SHALL be skipped (no compare), but the scan SHALL still take 16 edges.
REQ-017 Scan edge 16 SHALL register freq and peak from the final compare (including bin 15) and set done=1 for exactly one cycle; latency is 16 cycles from the capture edge to done visible.
REQ-018 freq and peak SHALL hold their values until the next done.
REQ-019 The block SHALL have a one-deep shadow buffer: fft_valid during SCAN SHALL load the shadow if it is empty.
REQ-020 If the shadow is full, a new frame SHALL be dropped and overflow set, except on scan edge 16.
REQ-021 At scan edge 16, a full shadow SHALL transfer to the working buffer and the next scan SHALL start at the following edge, with no idle cycle.
REQ-022 If fft_valid=1 on scan edge 16 with the shadow full, the shadow SHALL move to working and the new frame SHALL enter the shadow, with no drop.
REQ-023 If fft_valid=1 on scan edge 16 with the shadow empty, the new frame SHALL load working directly and the next scan SHALL start at the next edge.
REQ-024 busy SHALL be 1 from the edge after capture through scan edge 16, and SHALL stay 1 across back-to-back scans.
REQ-025 overflow SHALL be cleared only by reset.

Reset
REQ-026 rst=0 SHALL immediately force: done=0, freq=0, peak=0, busy=0, overflow=0, state IDLE, shadow empty, running max 0.
REQ-027 Reset asserted mid-scan SHALL abort the scan and discard both buffers; no done SHALL follow.
REQ-028 The first capture SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-029 The macro ANALYSIS_L1_MAG_EN SHALL select the magnitude function.
REQ-030 With ANALYSIS_L1_MAG_EN defined, mag = |re| + |im|, a 17-bit result zero-extended to 33 bits, with no multipliers; |-32768| = 32768.
REQ-031 Without ANALYSIS_L1_MAG_EN, the squared magnitude of REQ-014 SHALL be used.
REQ-032 Tie-break, timing and all other behaviour SHALL be identical in both builds.

Verification
REQ-033 Scenario: frame with bin1 = bin15 = 0x0100_0000 and all other bins 0 -> done 16 cycles later, freq=1, peak=0x0_0001_0000 (L1 build: 0x100).
REQ-034 Scenario: frame with bin0 = 0x0800_0000 and bin3 = 0x0000_0400, IGNORE_DC=1 -> freq=3; IGNORE_DC=0 -> freq=0.
REQ-035 Scenario: three frames at capture edges 0, 5, 7 -> third frame dropped and overflow=1; two done pulses at cycles 16 and 32 with correct freq values.
REQ-036 Scenario: second frame presented exactly on scan edge 16 of the first -> done at cycles 16 and 32, no overflow, busy never drops.
REQ-037 Scenario: rst pulled low at scan edge 8 -> all outputs 0 immediately and no done pulse; a new frame after release completes normally.
REQ-038 Scenario: bin2 = 0x8000_8000 (the most negative value) -> squared build peak=0x0_8000_0000, L1 build peak=0x1_0000; freq=2.
